// File: rtl/control_sequencer_if.sv
// Bus-control bundle between the sequencer and the datapath: opcode in, strobes/selects out.
// With ILLEGAL_TRAP_EN defined the bundle also carries the sticky illegal_flag.
interface control_sequencer_if;
  logic [7:0] opcode;
  logic       memory_enable;
  logic       memory_load;
  logic       opcode_reg_load;
  logic       register_bank_enable;
  logic       register_bank_load;
  logic [1:0] reg_rd_sel;
  logic [1:0] reg_wr_sel;
  logic       addr_sel;
  logic       addr_reg_load;
  logic       pc_inc;
  logic       halted;
  logic       illegal_op;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_flag;
`endif

  modport master (
    input  opcode,
    output memory_enable, memory_load, opcode_reg_load,
           register_bank_enable, register_bank_load,
           reg_rd_sel, reg_wr_sel, addr_sel, addr_reg_load,
           pc_inc, halted, illegal_op
`ifdef ILLEGAL_TRAP_EN
           , illegal_flag
`endif
  );

  modport slave (
    output opcode,
    input  memory_enable, memory_load, opcode_reg_load,
           register_bank_enable, register_bank_load,
           reg_rd_sel, reg_wr_sel, addr_sel, addr_reg_load,
           pc_inc, halted, illegal_op
`ifdef ILLEGAL_TRAP_EN
           , illegal_flag
`endif
  );
endinterface

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit processor; drives all bus strobes and selects.
// ILLEGAL_TRAP_EN: undefined ops trap to HALT and set a sticky illegal_flag.
module control_sequencer #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  control_sequencer_if.master  bus
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC0, EXEC1, HALT} state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_MOV = 4'h4;
  localparam logic [3:0] OP_HLT = 4'hF;
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t     state;
  logic [3:0] wait_cnt;
  logic [3:0] op;
  logic [1:0] rd, rs;
  logic       illegal, mem_state, wait_done;

  assign op = bus.opcode[7:4];
  assign rd = bus.opcode[3:2];
  assign rs = bus.opcode[1:0];
  assign illegal = !(op inside {OP_NOP, OP_LDI, OP_LD, OP_ST, OP_MOV, OP_HLT});

  // States touching memory are stretched to MEM_WAIT+1 cycles; all others last one cycle.
  assign mem_state = (state == FETCH) || (state == EXEC1) ||
                     ((state == EXEC0) && (op inside {OP_LDI, OP_LD, OP_ST}));
  assign wait_done = !mem_state || (wait_cnt == WAIT_LAST);

`ifdef ILLEGAL_TRAP_EN
  logic illegal_flag;
  assign bus.illegal_flag = illegal_flag;
`endif

  // State only advances on wait_done, so clearing the counter there clears it on every change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegal_flag <= 1'b0;
`endif
    end else begin
      wait_cnt <= wait_done ? 4'd0 : wait_cnt + 4'd1;
      case (state)
        IDLE:   state <= FETCH;
        FETCH:  if (wait_done) state <= DECODE;
        DECODE: begin
          case (op)
            OP_NOP:                       state <= FETCH;
            OP_LDI, OP_LD, OP_ST, OP_MOV: state <= EXEC0;
            OP_HLT:                       state <= HALT;
            default: begin
`ifdef ILLEGAL_TRAP_EN
              state        <= HALT;
              illegal_flag <= 1'b1;
`else
              state <= FETCH;
`endif
            end
          endcase
        end
        EXEC0:  if (wait_done) state <= (op == OP_LD || op == OP_ST) ? EXEC1 : FETCH;
        EXEC1:  if (wait_done) state <= FETCH;
        HALT:   state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.memory_enable        = 1'b0;
    bus.memory_load          = 1'b0;
    bus.opcode_reg_load      = 1'b0;
    bus.register_bank_enable = 1'b0;
    bus.register_bank_load   = 1'b0;
    bus.reg_rd_sel           = 2'd0;
    bus.reg_wr_sel           = 2'd0;
    bus.addr_sel             = 1'b0;
    bus.addr_reg_load        = 1'b0;
    bus.pc_inc               = 1'b0;
    bus.halted               = 1'b0;
    bus.illegal_op           = 1'b0;
    case (state)
      FETCH: begin
        bus.memory_enable   = 1'b1;
        bus.opcode_reg_load = 1'b1;
        bus.pc_inc          = wait_done;
      end
      DECODE: bus.illegal_op = illegal;
      EXEC0: begin
        case (op)
          OP_LDI: begin
            bus.memory_enable      = 1'b1;
            bus.register_bank_load = 1'b1;
            bus.reg_wr_sel         = rd;
            bus.pc_inc             = wait_done;
          end
          OP_LD, OP_ST: begin
            bus.memory_enable = 1'b1;
            bus.addr_reg_load = 1'b1;
            bus.pc_inc        = wait_done;
          end
          OP_MOV: begin
            bus.register_bank_enable = 1'b1;
            bus.register_bank_load   = 1'b1;
            bus.reg_rd_sel           = rs;
            bus.reg_wr_sel           = rd;
          end
          default: ;
        endcase
      end
      EXEC1: begin
        case (op)
          OP_LD: begin
            bus.addr_sel           = 1'b1;
            bus.memory_enable      = 1'b1;
            bus.register_bank_load = 1'b1;
            bus.reg_wr_sel         = rd;
          end
          OP_ST: begin
            bus.addr_sel             = 1'b1;
            bus.register_bank_enable = 1'b1;
            bus.reg_rd_sel           = rs;
            bus.memory_load          = 1'b1;
          end
          default: ;
        endcase
      end
      HALT: bus.halted = 1'b1;
      default: ;
    endcase
  end
endmodule
